// File: rtl/fsm_pkg.sv
// Shared definitions for the serial frame transmitter and detector-side FSMs.
// Holds the state encodings and the line levels used for idle/start/stop.
// No logic; constants only.
package fsm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

endpackage

// File: rtl/fsm_tx_shift.sv
// Loadable left-shift register with saturating bit counter and captured even parity.
// Latency: load/shift take effect on the next rising edge.
// No backpressure: the controller decides when to load and when to shift.
module fsm_tx_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic              msb_o,
    output logic              next_msb_o,
    output logic              last_bit_o,
    output logic              parity_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;

    // Next-state: load wins over shift; counter holds once it reaches DATA_W.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        par_d = par_q;
        if (load_i) begin
            sr_d  = data_i;
            cnt_d = '0;
            par_d = ^data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[DATA_W-2:0], 1'b0};
            if (cnt_q != CNT_W'(DATA_W)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
            par_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            par_q <= par_d;
        end
    end

    // The bit after the current MSB is what goes on the line after a shift.
    assign msb_o      = sr_q[DATA_W-1];
    assign next_msb_o = sr_q[DATA_W-2];
    // True on the shift edge that retires the final data bit.
    assign last_bit_o = (cnt_q == CNT_W'(DATA_W - 1));
    assign parity_o   = par_q;

endmodule

// File: rtl/fsm_serial_tx.sv
// Serial frame transmitter: start(1), data MSB first, optional even parity, stop(0).
// Latency: line changes one edge after accept; frame is DATA_W+2+PARITY_EN cycles.
// Ready only in IDLE/STOP; a new word accepted in STOP follows with no idle gap.
module fsm_serial_tx
    import fsm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_data_out,
    output logic              o_busy,
    output logic              o_done
);

    state_e state_q;
    logic   line_q;
    logic   accept;
    logic   shift;
    logic   msb;
    logic   next_msb;
    logic   last_bit;
    logic   parity;

    assign o_ready = (state_q == IDLE) || (state_q == STOP);
    assign accept  = i_load && o_ready;
    assign shift   = (state_q == DATA);

    fsm_tx_shift #(
        .DATA_W(DATA_W)
    ) u_shift (
        .clk_i      (i_sys_clk),
        .rst_i      (i_rst),
        .load_i     (accept),
        .data_i     (i_data),
        .shift_i    (shift),
        .msb_o      (msb),
        .next_msb_o (next_msb),
        .last_bit_o (last_bit),
        .parity_o   (parity)
    );

    // Control FSM; the line value is registered alongside the state it belongs to.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            line_q  <= LINE_IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= START;
                        line_q  <= LINE_START;
                    end else begin
                        line_q  <= LINE_IDLE;
                    end
                end
                START: begin
                    state_q <= DATA;
                    line_q  <= msb;
                end
                DATA: begin
                    if (last_bit) begin
                        if (PARITY_EN != 0) begin
                            state_q <= PARITY;
                            line_q  <= parity;
                        end else begin
                            state_q <= STOP;
                            line_q  <= LINE_STOP;
                        end
                    end else begin
                        line_q <= next_msb;
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    line_q  <= LINE_STOP;
                end
                STOP: begin
                    if (accept) begin
                        state_q <= START;
                        line_q  <= LINE_START;
                    end else begin
                        state_q <= IDLE;
                        line_q  <= LINE_IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    line_q  <= LINE_IDLE;
                end
            endcase
        end
    end

    assign o_data_out = line_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == STOP);

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Bench for fsm_serial_tx: one instance without parity, one with, sharing clock/reset/data.
module tb_fsm_serial_tx;

    typedef struct packed {
        logic line;
        logic done;
        logic busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       load  [2];
    logic       ready [2];
    logic       line  [2];
    logic       busy  [2];
    logic       done  [2];

    exp_t q [2][$];
    logic mrdy [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fsm_serial_tx #(.DATA_W(8), .PARITY_EN(0)) dut0 (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .i_load    (load[0]),
        .i_data    (data),
        .o_ready   (ready[0]),
        .o_data_out(line[0]),
        .o_busy    (busy[0]),
        .o_done    (done[0])
    );

    fsm_serial_tx #(.DATA_W(8), .PARITY_EN(1)) dut1 (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .i_load    (load[1]),
        .i_data    (data),
        .o_ready   (ready[1]),
        .o_data_out(line[1]),
        .o_busy    (busy[1]),
        .o_done    (done[1])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected frame for one accepted word, one entry per line cycle.
    task automatic push_frame(input int d, input logic [7:0] v);
        exp_t e;
        e = '{line: 1'b1, done: 1'b0, busy: 1'b1};
        q[d].push_back(e);
        for (int i = 7; i >= 0; i--) begin
            e = '{line: v[i], done: 1'b0, busy: 1'b1};
            q[d].push_back(e);
        end
        if (d == 1) begin
            e = '{line: ^v, done: 1'b0, busy: 1'b1};
            q[d].push_back(e);
        end
        e = '{line: 1'b0, done: 1'b1, busy: 1'b1};
        q[d].push_back(e);
    endtask

    // Compare one cycle of DUT d against the scoreboard head (or idle if empty).
    task automatic check_cycle(input int d, input string tag);
        exp_t e;
        if (q[d].size() > 0) begin
            e = q[d].pop_front();
        end else begin
            e = '{line: 1'b0, done: 1'b0, busy: 1'b0};
        end
        mrdy[d] = e.done || !e.busy;
        chk($sformatf("%s.d%0d.line", tag, d), line[d], e.line);
        chk($sformatf("%s.d%0d.done", tag, d), done[d], e.done);
        chk($sformatf("%s.d%0d.busy", tag, d), busy[d], e.busy);
        chk($sformatf("%s.d%0d.ready", tag, d), ready[d], mrdy[d]);
    endtask

    // One clock: decide accepts from the model, push frames, then check at negedge.
    task automatic tick(input string tag);
        bit         acc [2];
        logic [7:0] dv;
        dv = data;
        for (int d = 0; d < 2; d++) acc[d] = load[d] && mrdy[d] && !rst;
        @(posedge clk);
        for (int d = 0; d < 2; d++) if (acc[d]) push_frame(d, dv);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_cycle(d, tag);
    endtask

    initial begin
        rst = 1'b1;
        data = 8'h00;
        load[0] = 1'b0;
        load[1] = 1'b0;
        mrdy[0] = 1'b1;
        mrdy[1] = 1'b1;

        // Reset values.
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst.d%0d.line", d), line[d], 1'b0);
            chk($sformatf("rst.d%0d.busy", d), busy[d], 1'b0);
            chk($sformatf("rst.d%0d.done", d), done[d], 1'b0);
            chk($sformatf("rst.d%0d.ready", d), ready[d], 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick("idle");

        // 0xA5 on both: plain 10-cycle frame and 11-cycle parity frame (parity 0).
        data = 8'hA5;
        load[0] = 1'b1;
        load[1] = 1'b1;
        tick("a5");
        load[0] = 1'b0;
        load[1] = 1'b0;
        data = 8'h00;
        repeat (12) tick("a5");

        // Parity frames: 0x07 (parity 1), then 0x03 (parity 0).
        data = 8'h07;
        load[1] = 1'b1;
        tick("p07");
        load[1] = 1'b0;
        repeat (11) tick("p07");
        data = 8'h03;
        load[1] = 1'b1;
        tick("p03");
        load[1] = 1'b0;
        repeat (11) tick("p03");

        // Back-to-back with load held: 0x81 then 0x7E, no idle gap.
        data = 8'h81;
        load[0] = 1'b1;
        tick("b2b");
        data = 8'h7E;
        repeat (10) tick("b2b");
        load[0] = 1'b0;
        data = 8'h00;
        repeat (11) tick("b2b");

        // Load pulse and data change mid-frame are ignored.
        data = 8'h3C;
        load[0] = 1'b1;
        load[1] = 1'b1;
        tick("ign");
        load[0] = 1'b0;
        load[1] = 1'b0;
        repeat (3) tick("ign");
        data = 8'hFF;
        load[0] = 1'b1;
        load[1] = 1'b1;
        tick("ign");
        load[0] = 1'b0;
        load[1] = 1'b0;
        data = 8'h55;
        repeat (9) tick("ign");

        // Partial-cycle reset at the 4th data bit.
        data = 8'hC3;
        load[0] = 1'b1;
        load[1] = 1'b1;
        tick("mrst");
        load[0] = 1'b0;
        load[1] = 1'b0;
        repeat (4) tick("mrst");
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mrst.d%0d.line_async", d), line[d], 1'b0);
            chk($sformatf("mrst.d%0d.busy_async", d), busy[d], 1'b0);
            chk($sformatf("mrst.d%0d.done_async", d), done[d], 1'b0);
            q[d].delete();
            mrdy[d] = 1'b1;
        end
        #1 rst = 1'b0;
        data = 8'hFF;
        load[0] = 1'b1;
        tick("ff");
        load[0] = 1'b0;
        repeat (10) tick("ff");

        // Reset held across edges with load high: no accept until release.
        @(negedge clk);
        rst = 1'b1;
        data = 8'h96;
        load[0] = 1'b1;
        load[1] = 1'b1;
        repeat (3) tick("rload");
        rst = 1'b0;
        tick("rload");
        load[0] = 1'b0;
        load[1] = 1'b0;
        repeat (11) tick("rload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
